// File: rtl/vlsu_pkg.sv
// Shared types and sizing for the VLSU sequential load path.
// Sequential buffers are nibble-granular so the shuffle stage can mask half-bytes.
package vlsu_pkg;

    localparam int NrLanes      = 4;
    localparam int DLEN         = 64;
    localparam int AxiDataWidth = 128;
    localparam int MaxLenBits   = 16;

    localparam int BeatBytes = AxiDataWidth / 8;
    localparam int SeqBytes  = NrLanes * DLEN / 8;
    localparam int SeqNbs    = 2 * SeqBytes;
    localparam int SeqBits   = SeqBytes * 8;
    localparam int OffBits   = $clog2(BeatBytes);
    localparam int PtrBits   = $clog2(SeqBytes) + 1;
    // One extra bit so wr_ptr + n never wraps.
    localparam int AccBits   = PtrBits + 1;

    typedef struct packed {
        logic [SeqNbs-1:0][3:0] nb;
        logic [SeqNbs-1:0]      en;
    } seq_buf_t;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_FILL  = 2'd1,
        SEQ_FLUSH = 2'd2
    } seq_asm_state_e;

    function automatic logic [SeqNbs-1:0] expand_ben(input logic [SeqBytes-1:0] ben);
        logic [SeqNbs-1:0] en;
        en = '0;
        for (int k = 0; k < SeqBytes; k++) begin
            en[2*k +: 2] = {2{ben[k]}};
        end
        return en;
    endfunction

endpackage

// File: rtl/seq_byte_packer.sv
// Places the n useful bytes of one R beat (starting at lo) at sequential byte wr_ptr.
// Bytes landing past the end of the buffer come out on ovf_bytes, starting at byte 0.
module seq_byte_packer
    import vlsu_pkg::*;
(
    input  logic [AxiDataWidth-1:0] data,
    input  logic [OffBits-1:0]      lo,
    input  logic [OffBits:0]        n,
    input  logic [PtrBits-1:0]      wr_ptr,
    output logic [SeqBits-1:0]      seq_bytes,
    output logic [SeqBytes-1:0]     seq_ben,
    output logic [AxiDataWidth-1:0] ovf_bytes
);

    localparam int WideBytes = SeqBytes + BeatBytes;

    logic [AxiDataWidth-1:0]  win_s;
    logic [WideBytes*8-1:0]   wide_s;
    logic [WideBytes*8-1:0]   masked_s;
    logic [WideBytes-1:0]     ben_s;
    logic [AccBits-1:0]       end_s;

    // Shift, place and byte-mask the beat over a buffer-plus-overflow window.
    always_comb begin
        win_s    = data >> {lo, 3'b000};
        wide_s   = {{SeqBits{1'b0}}, win_s} << {wr_ptr, 3'b000};
        end_s    = AccBits'(wr_ptr) + AccBits'(n);
        ben_s    = '0;
        masked_s = '0;
        for (int k = 0; k < WideBytes; k++) begin
            ben_s[k] = (AccBits'(k) >= AccBits'(wr_ptr)) && (AccBits'(k) < end_s);
            masked_s[k*8 +: 8] = wide_s[k*8 +: 8] & {8{ben_s[k]}};
        end
        seq_bytes = masked_s[SeqBits-1:0];
        seq_ben   = ben_s[SeqBytes-1:0];
        ovf_bytes = masked_s[WideBytes*8-1:SeqBits];
    end

endmodule

// File: rtl/seq_load_assembler.sv
// Packs AXI R beats of one load request into contiguous sequential buffers
// and hands each buffer to the shuffle stage over valid/ready.
module seq_load_assembler
    import vlsu_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [OffBits-1:0]      cmd_off_i,
    input  logic [MaxLenBits-1:0]   cmd_len_i,
    input  logic                    axi_r_valid_i,
    output logic                    axi_r_ready_o,
    input  logic [AxiDataWidth-1:0] axi_r_data_i,
    input  logic                    axi_r_last_i,
    output logic                    tx_seq_load_valid_o,
    input  logic                    tx_seq_load_ready_i,
    output seq_buf_t                tx_seq_load_o,
    output logic                    busy_o,
    output logic                    err_o
);

    seq_asm_state_e          state_r;
    seq_buf_t                buf_r;
    logic [AxiDataWidth-1:0] carry_r;
    logic [AccBits-1:0]      carry_cnt_r;
    logic [PtrBits-1:0]      wr_ptr_r;
    logic [MaxLenBits-1:0]   remaining_r;
    logic [OffBits-1:0]      off_r;
    logic                    first_beat_r;
    logic                    cmd_ready_r;
    logic                    r_ready_r;
    logic                    valid_r;
    logic                    busy_r;
    logic                    err_r;

    logic [OffBits-1:0]      lo_s;
    logic [MaxLenBits-1:0]   avail_s;
    logic [MaxLenBits-1:0]   n_wide_s;
    logic [OffBits:0]        n_s;
    logic [AccBits-1:0]      sum_s;
    logic                    full_s;
    logic [AccBits-1:0]      excess_s;
    logic [MaxLenBits-1:0]   rem_next_s;
    logic                    done_s;
    logic [SeqBytes-1:0]     carry_ben_s;
    logic [SeqBits-1:0]      seq_bytes_s;
    logic [SeqBytes-1:0]     seq_ben_s;
    logic [AxiDataWidth-1:0] ovf_bytes_s;

    // Per-beat byte count and buffer-fill arithmetic, kept in full length width.
    always_comb begin
        lo_s       = first_beat_r ? off_r : '0;
        avail_s    = MaxLenBits'(BeatBytes) - MaxLenBits'(lo_s);
        n_wide_s   = (avail_s < remaining_r) ? avail_s : remaining_r;
        n_s        = n_wide_s[OffBits:0];
        sum_s      = AccBits'(wr_ptr_r) + AccBits'(n_s);
        full_s     = (sum_s >= AccBits'(SeqBytes));
        excess_s   = full_s ? (sum_s - AccBits'(SeqBytes)) : '0;
        rem_next_s = remaining_r - n_wide_s;
        done_s     = (rem_next_s == '0);
        carry_ben_s = '0;
        for (int k = 0; k < SeqBytes; k++) begin
            carry_ben_s[k] = (AccBits'(k) < carry_cnt_r);
        end
    end

    seq_byte_packer u_packer (
        .data      (axi_r_data_i),
        .lo        (lo_s),
        .n         (n_s),
        .wr_ptr    (wr_ptr_r),
        .seq_bytes (seq_bytes_s),
        .seq_ben   (seq_ben_s),
        .ovf_bytes (ovf_bytes_s)
    );

    // Assembler FSM: state, datapath registers and registered handshake outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= SEQ_IDLE;
            buf_r        <= '0;
            carry_r      <= '0;
            carry_cnt_r  <= '0;
            wr_ptr_r     <= '0;
            remaining_r  <= '0;
            off_r        <= '0;
            first_beat_r <= 1'b0;
            cmd_ready_r  <= 1'b1;
            r_ready_r    <= 1'b0;
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            case (state_r)
                SEQ_IDLE: begin
                    if (cmd_valid_i) begin
                        off_r        <= cmd_off_i;
                        remaining_r  <= cmd_len_i;
                        first_beat_r <= 1'b1;
                        state_r      <= SEQ_FILL;
                        cmd_ready_r  <= 1'b0;
                        r_ready_r    <= 1'b1;
                        busy_r       <= 1'b1;
                        if (cmd_len_i == '0) err_r <= 1'b1;
                    end
                end
                SEQ_FILL: begin
                    if (axi_r_valid_i) begin
                        buf_r.nb     <= buf_r.nb | seq_bytes_s;
                        buf_r.en     <= buf_r.en | expand_ben(seq_ben_s);
                        carry_r      <= ovf_bytes_s;
                        carry_cnt_r  <= excess_s;
                        wr_ptr_r     <= full_s ? '0 : sum_s[PtrBits-1:0];
                        remaining_r  <= rem_next_s;
                        first_beat_r <= 1'b0;
                        if (axi_r_last_i != done_s) err_r <= 1'b1;
                        if (full_s || done_s) begin
                            state_r   <= SEQ_FLUSH;
                            valid_r   <= 1'b1;
                            r_ready_r <= 1'b0;
                        end
                    end
                end
                SEQ_FLUSH: begin
                    if (tx_seq_load_ready_i) begin
                        // Straddling bytes become the head of the next buffer.
                        buf_r.nb    <= SeqBits'(carry_r);
                        buf_r.en    <= expand_ben(carry_ben_s);
                        wr_ptr_r    <= PtrBits'(carry_cnt_r);
                        carry_cnt_r <= '0;
                        carry_r     <= '0;
                        if (remaining_r != '0) begin
                            state_r   <= SEQ_FILL;
                            valid_r   <= 1'b0;
                            r_ready_r <= 1'b1;
                        end else if (carry_cnt_r != '0) begin
                            state_r   <= SEQ_FLUSH;
                            valid_r   <= 1'b1;
                        end else begin
                            state_r     <= SEQ_IDLE;
                            valid_r     <= 1'b0;
                            cmd_ready_r <= 1'b1;
                            busy_r      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r     <= SEQ_IDLE;
                    cmd_ready_r <= 1'b1;
                    r_ready_r   <= 1'b0;
                    valid_r     <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o         = cmd_ready_r;
    assign axi_r_ready_o       = r_ready_r;
    assign tx_seq_load_valid_o = valid_r;
    assign tx_seq_load_o       = buf_r;
    assign busy_o              = busy_r;
    assign err_o               = err_r;

endmodule

// File: tb/tb_seq_load_assembler.sv
// Directed bench for seq_load_assembler: buffer packing, carry, stall, error and reset.
module tb_seq_load_assembler;
    import vlsu_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [OffBits-1:0]      cmd_off;
    logic [MaxLenBits-1:0]   cmd_len;
    logic                    r_valid;
    logic                    r_ready;
    logic [AxiDataWidth-1:0] r_data;
    logic                    r_last;
    logic                    tx_valid;
    logic                    tx_ready;
    seq_buf_t                tx;
    logic                    busy;
    logic                    err;

    int total = 0;
    int bad   = 0;

    logic [SeqBits-1:0] exp_nb;
    logic [SeqNbs-1:0]  exp_en;

    always #5 clk = ~clk;

    seq_load_assembler dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .cmd_valid_i         (cmd_valid),
        .cmd_ready_o         (cmd_ready),
        .cmd_off_i           (cmd_off),
        .cmd_len_i           (cmd_len),
        .axi_r_valid_i       (r_valid),
        .axi_r_ready_o       (r_ready),
        .axi_r_data_i        (r_data),
        .axi_r_last_i        (r_last),
        .tx_seq_load_valid_o (tx_valid),
        .tx_seq_load_ready_i (tx_ready),
        .tx_seq_load_o       (tx),
        .busy_o              (busy),
        .err_o               (err)
    );

    function automatic logic [AxiDataWidth-1:0] make_beat(input logic [7:0] base);
        logic [AxiDataWidth-1:0] d;
        d = '0;
        for (int i = 0; i < BeatBytes; i++) d[8*i +: 8] = base + 8'(i);
        return d;
    endfunction

    task automatic send_cmd(input logic [OffBits-1:0] off, input logic [MaxLenBits-1:0] len);
        cmd_off   = off;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [AxiDataWidth-1:0] d, input logic last);
        int waited;
        waited  = 0;
        r_data  = d;
        r_last  = last;
        r_valid = 1'b1;
        while (!r_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (r_ready !== 1'b1) begin
            bad++;
            $display("FAIL beat_accept_timeout r_ready=%0b required=1", r_ready);
        end
        @(negedge clk);
        r_valid = 1'b0;
        r_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%0b exp=1", cmd_ready); end
        total++; if (r_ready !== 1'b0) begin bad++; $display("FAIL rst_r_ready got=%0b exp=0", r_ready); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", tx_valid); end
        total++; if (tx !== '0) begin bad++; $display("FAIL rst_tx got=%h exp=0", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", err); end
    endtask

    task automatic test_full_buffer();
        tx_ready = 1'b1;
        for (int k = 0; k < SeqBytes; k++) exp_nb[8*k +: 8] = 8'(k);
        exp_en = {SeqNbs{1'b1}};
        send_cmd(4'd0, 16'd32);
        send_beat(make_beat(8'h00), 1'b0);
        send_beat(make_beat(8'h10), 1'b1);
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%0b exp=1", tx_valid); end
        total++; if (tx.nb !== exp_nb) begin bad++; $display("FAIL full_nb got=%h exp=%h", tx.nb, exp_nb); end
        total++; if (tx.en !== exp_en) begin bad++; $display("FAIL full_en got=%h exp=%h", tx.en, exp_en); end
        @(negedge clk);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL full_valid_drop got=%0b exp=0", tx_valid); end
        total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL full_idle cmd_ready=%0b busy=%0b exp=1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_carry();
        tx_ready = 1'b1;
        for (int k = 0; k < SeqBytes; k++) exp_nb[8*k +: 8] = 8'(8'h44 + k);
        exp_en = {SeqNbs{1'b1}};
        send_cmd(4'd4, 16'd40);
        send_beat(make_beat(8'h40), 1'b0);
        send_beat(make_beat(8'h50), 1'b0);
        send_beat(make_beat(8'h60), 1'b1);
        total++; if (tx_valid !== 1'b1 || r_ready !== 1'b0) begin
            bad++; $display("FAIL carry_buf1_hs valid=%0b r_ready=%0b exp=1/0", tx_valid, r_ready);
        end
        total++; if (tx.nb !== exp_nb) begin bad++; $display("FAIL carry_buf1_nb got=%h exp=%h", tx.nb, exp_nb); end
        total++; if (tx.en !== exp_en) begin bad++; $display("FAIL carry_buf1_en got=%h exp=%h", tx.en, exp_en); end
        exp_nb = '0;
        for (int k = 0; k < 8; k++) exp_nb[8*k +: 8] = 8'(8'h64 + k);
        exp_en = {{(SeqNbs-16){1'b0}}, {16{1'b1}}};
        @(negedge clk);
        total++; if (tx_valid !== 1'b1 || r_ready !== 1'b0) begin
            bad++; $display("FAIL carry_buf2_hs valid=%0b r_ready=%0b exp=1/0", tx_valid, r_ready);
        end
        total++; if (tx.nb !== exp_nb) begin bad++; $display("FAIL carry_buf2_nb got=%h exp=%h", tx.nb, exp_nb); end
        total++; if (tx.en !== exp_en) begin bad++; $display("FAIL carry_buf2_en got=%h exp=%h", tx.en, exp_en); end
        @(negedge clk);
        total++; if (tx_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL carry_idle valid=%0b cmd_ready=%0b exp=0/1", tx_valid, cmd_ready);
        end
    endtask

    task automatic test_stall();
        tx_ready = 1'b0;
        for (int k = 0; k < SeqBytes; k++) exp_nb[8*k +: 8] = 8'(k);
        exp_en = {SeqNbs{1'b1}};
        send_cmd(4'd0, 16'd32);
        send_beat(make_beat(8'h00), 1'b0);
        send_beat(make_beat(8'h10), 1'b1);
        for (int c = 0; c < 5; c++) begin
            total++;
            if (tx_valid !== 1'b1 || r_ready !== 1'b0 || tx.nb !== exp_nb || tx.en !== exp_en) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d valid=%0b r_ready=%0b nb=%h exp_valid=1 exp_r_ready=0 exp_nb=%h",
                         c, tx_valid, r_ready, tx.nb, exp_nb);
            end
            @(negedge clk);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        total++; if (tx_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL stall_release valid=%0b cmd_ready=%0b exp=0/1", tx_valid, cmd_ready);
        end
    endtask

    task automatic test_single_byte();
        tx_ready = 1'b1;
        exp_nb = '0;
        exp_nb[7:0] = 8'hAF;
        exp_en = {{(SeqNbs-2){1'b0}}, 2'b11};
        send_cmd(4'd15, 16'd1);
        send_beat(make_beat(8'hA0), 1'b1);
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", tx_valid); end
        total++; if (tx.nb !== exp_nb) begin bad++; $display("FAIL single_nb got=%h exp=%h", tx.nb, exp_nb); end
        total++; if (tx.en !== exp_en) begin bad++; $display("FAIL single_en got=%h exp=%h", tx.en, exp_en); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL single_err got=%0b exp=0", err); end
        @(negedge clk);
    endtask

    task automatic test_early_last();
        tx_ready = 1'b1;
        send_cmd(4'd0, 16'd48);
        send_beat(make_beat(8'h00), 1'b0);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL early_err_pre got=%0b exp=0", err); end
        send_beat(make_beat(8'h10), 1'b1);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL early_err_set got=%0b exp=1", err); end
        repeat (2) @(negedge clk);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL early_err_sticky got=%0b exp=1", err); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (err !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL early_err_clear err=%0b busy=%0b exp=0/0", err, busy);
        end
    endtask

    task automatic test_reset_mid_fill();
        tx_ready = 1'b1;
        send_cmd(4'd0, 16'd32);
        send_beat(make_beat(8'hE0), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (tx_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || r_ready !== 1'b0) begin
            bad++; $display("FAIL midrst_state valid=%0b cmd_ready=%0b busy=%0b r_ready=%0b exp=0/1/0/0",
                            tx_valid, cmd_ready, busy, r_ready);
        end
        exp_nb = '0;
        for (int k = 0; k < 16; k++) exp_nb[8*k +: 8] = 8'(8'h10 + k);
        exp_en = {{(SeqNbs-32){1'b0}}, {32{1'b1}}};
        send_cmd(4'd0, 16'd16);
        send_beat(make_beat(8'h10), 1'b1);
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL midrst_valid got=%0b exp=1", tx_valid); end
        total++; if (tx.nb !== exp_nb) begin bad++; $display("FAIL midrst_nb got=%h exp=%h", tx.nb, exp_nb); end
        total++; if (tx.en !== exp_en) begin bad++; $display("FAIL midrst_en got=%h exp=%h", tx.en, exp_en); end
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_idle got=%0b exp=1", cmd_ready); end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_off   = '0;
        cmd_len   = '0;
        r_valid   = 1'b0;
        r_data    = '0;
        r_last    = 1'b0;
        tx_ready  = 1'b0;
        exp_nb    = '0;
        exp_en    = '0;
        @(negedge clk);
        test_reset();
        test_full_buffer();
        test_carry();
        test_stall();
        test_single_byte();
        test_early_last();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
